// File: rtl/setting_reg.sv
// rtl/setting_reg.sv - one addressed setting register on the 8-bit setting bus
module setting_reg #(
    parameter int               my_addr  = 0,
    parameter int               width    = 32,
    parameter logic [width-1:0] at_reset = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      in,
    output logic [width-1:0] out
);

    logic [width-1:0] out_q;
    logic [width-1:0] out_d;

    // Capture the low bits of the bus on a write to this register's address.
    always_comb begin
        out_d = out_q;
        if (strobe && (addr == 8'(my_addr))) begin
            out_d = in[width-1:0];
        end
    end

    // Register state; only the hard reset restores the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= at_reset;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/eth_pad36.sv
// rtl/eth_pad36.sv - pads short 36-bit line-interface frames up to the minimum length
module eth_pad36 #(
    parameter int BASE      = 0,
    parameter int MIN_BYTES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [35:0] data_i,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    output logic [35:0] data_o,
    output logic        src_rdy_o,
    input  logic        dst_rdy_i,
    output logic [15:0] pad_count,
    output logic [31:0] debug
);

    localparam int         MIN_LINES = MIN_BYTES / 4;
    localparam logic [8:0] MIN_L9    = 9'(MIN_LINES);

    localparam logic [1:0] OCC_FULL = 2'd0;
    localparam logic [1:0] OCC_1    = 2'd1;
    localparam logic [1:0] OCC_2    = 2'd2;
    localparam logic [1:0] OCC_3    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  line_cnt_q, line_cnt_d;
    logic [15:0] pad_count_q, pad_count_d;
    logic        frame_en_q, frame_en_d;

    logic        set_en;
    logic        en_eff;
    logic [8:0]  n;
    logic        in_eof;
    logic [1:0]  in_occ;
    logic        is_short;
    logic        is_exact_part;
    logic        pad_last;

    setting_reg #(
        .my_addr  (BASE),
        .width    (1),
        .at_reset (1'b1)
    ) u_enable_reg (
        .clk    (clk),
        .rst    (reset),
        .strobe (set_stb),
        .addr   (set_addr),
        .in     (set_data),
        .out    (set_en)
    );

    // Zero the bytes beyond the occupancy of an EOF line.
    function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [1:0] occ);
        case (occ)
            OCC_1:   keep_bytes = d & 32'hFF00_0000;
            OCC_2:   keep_bytes = d & 32'hFFFF_0000;
            OCC_3:   keep_bytes = d & 32'hFFFF_FF00;
            default: keep_bytes = d;
        endcase
    endfunction

    // Next-state, counters and the combinational data path.
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        pad_count_d = pad_count_q;
        frame_en_d  = frame_en_q;
        data_o      = data_i;
        src_rdy_o   = src_rdy_i;
        dst_rdy_o   = dst_rdy_i;

        // In IDLE the live register decides; once a frame starts the latched copy does.
        en_eff        = (state_q == ST_IDLE) ? set_en : frame_en_q;
        n             = {1'b0, line_cnt_q} + 9'd1;
        in_eof        = data_i[33];
        in_occ        = data_i[35:34];
        is_short      = (n < MIN_L9);
        is_exact_part = (n == MIN_L9) && (in_occ != OCC_FULL);
        pad_last      = (n == MIN_L9);

        case (state_q)
            ST_IDLE, ST_PASS: begin
                if (en_eff && in_eof && (is_short || is_exact_part)) begin
                    data_o = {OCC_FULL, ~is_short, data_i[32], keep_bytes(data_i[31:0], in_occ)};
                end
                if (src_rdy_i && dst_rdy_i) begin
                    if (state_q == ST_IDLE) begin
                        frame_en_d = set_en;
                    end
                    if (in_eof) begin
                        state_d    = ST_IDLE;
                        line_cnt_d = 8'd0;
                        if (en_eff && (is_short || is_exact_part) && (pad_count_q != 16'hFFFF)) begin
                            pad_count_d = pad_count_q + 16'd1;
                        end
                        if (en_eff && is_short) begin
                            state_d    = ST_PAD;
                            line_cnt_d = n[7:0];
                        end
                    end else begin
                        state_d    = ST_PASS;
                        line_cnt_d = (line_cnt_q == 8'hFF) ? line_cnt_q : line_cnt_q + 8'd1;
                    end
                end
            end
            ST_PAD: begin
                data_o    = {OCC_FULL, pad_last, 1'b0, 32'h0};
                src_rdy_o = 1'b1;
                dst_rdy_o = 1'b0;
                if (dst_rdy_i) begin
                    if (pad_last) begin
                        state_d    = ST_IDLE;
                        line_cnt_d = 8'd0;
                    end else begin
                        line_cnt_d = line_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                line_cnt_d = 8'd0;
            end
        endcase
    end

    // State registers; clear abandons the frame but keeps the counter and enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= 8'd0;
            pad_count_q <= 16'd0;
            frame_en_q  <= 1'b1;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            pad_count_q <= pad_count_d;
            frame_en_q  <= frame_en_d;
        end
    end

    assign pad_count = pad_count_q;
    assign debug     = {state_q, en_eff, line_cnt_q, 21'b0};

endmodule

// File: tb/tb_eth_pad36.sv
// tb/tb_eth_pad36.sv - directed self-checking bench for eth_pad36
module tb_eth_pad36;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [35:0] data_i;
    logic        src_rdy_i;
    logic        dst_rdy_o;
    logic [35:0] data_o;
    logic        src_rdy_o;
    logic        dst_rdy_i;
    logic [15:0] pad_count;
    logic [31:0] debug;

    int total = 0;
    int bad   = 0;
    int pad_rdy_viol = 0;
    int lat_viol     = 0;
    logic toggle = 1'b0;
    logic [35:0] in_q[$];
    logic [35:0] out_q[$];
    int base;

    eth_pad36 #(.BASE(0), .MIN_BYTES(60)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .data_i    (data_i),
        .src_rdy_i (src_rdy_i),
        .dst_rdy_o (dst_rdy_o),
        .data_o    (data_o),
        .src_rdy_o (src_rdy_o),
        .dst_rdy_i (dst_rdy_i),
        .pad_count (pad_count),
        .debug     (debug)
    );

    always #5 clk = ~clk;

    // Record every output transfer and flag handshake rule breaks, away from the edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (src_rdy_o && dst_rdy_i) out_q.push_back(data_o);
            if (src_rdy_i && dst_rdy_o && !(src_rdy_o && dst_rdy_i)) lat_viol++;
            if (src_rdy_o && !src_rdy_i && dst_rdy_o) pad_rdy_viol++;
        end
    end

    function automatic logic [35:0] mk(input logic sof, input logic eof, input logic [1:0] occ,
                                       input logic [31:0] d);
        mk = {occ, eof, sof, d};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) dst_rdy_i = ~dst_rdy_i;
    endtask

    // Drive in_q into the DUT honouring dst_rdy_o, then go quiet.
    task automatic send();
        logic acc;
        int   budget;
        for (int i = 0; i < in_q.size(); i++) begin
            data_i    = in_q[i];
            src_rdy_i = 1'b1;
            budget    = 0;
            acc       = 1'b0;
            while (!acc && budget < 100) begin
                #1;
                acc = dst_rdy_o && dst_rdy_i;
                tick();
                budget++;
            end
            if (!acc) chk("send_timeout", 36'd1, 36'd0);
        end
        src_rdy_i = 1'b0;
        data_i    = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) tick();
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        data_i = '0; src_rdy_i = 1'b1; dst_rdy_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("reset_src_rdy", 36'(src_rdy_o), 36'd1);
        chk("reset_dst_rdy", 36'(dst_rdy_o), 36'd0);
        chk("reset_pad_count", 36'(pad_count), 36'd0);
        chk("reset_debug", 36'(debug[29:0]), 36'h2000_0000);
        src_rdy_i = 1'b0; dst_rdy_i = 1'b1;
        tick();

        // 1-line frame, occ=2
        base = out_q.size();
        in_q = '{mk(1, 1, 2, 32'hAABBCCDD)};
        send(); drain();
        chk("t1_count", 36'(out_q.size() - base), 36'd15);
        chk("t1_line0", out_q[base], mk(1, 0, 0, 32'hAABB0000));
        for (int i = 1; i < 14; i++) chk("t1_pad", out_q[base+i], 36'd0);
        chk("t1_last", out_q[base+14], mk(0, 1, 0, 32'h0));
        chk("t1_pad_count", 36'(pad_count), 36'd1);

        // 15-line frame, last occ=1
        base = out_q.size();
        in_q = {};
        for (int i = 0; i < 14; i++) in_q.push_back(mk(i == 0, 0, 0, 32'h1000 + i));
        in_q.push_back(mk(0, 1, 1, 32'h11223344));
        send(); drain();
        chk("t2_count", 36'(out_q.size() - base), 36'd15);
        for (int i = 0; i < 14; i++) chk("t2_body", out_q[base+i], mk(i == 0, 0, 0, 32'h1000 + i));
        chk("t2_last", out_q[base+14], mk(0, 1, 0, 32'h11000000));
        chk("t2_pad_count", 36'(pad_count), 36'd2);

        // 16-line frame (occ=3) and 15-line frame (occ=0) pass untouched
        base = out_q.size();
        in_q = {};
        for (int i = 0; i < 15; i++) in_q.push_back(mk(i == 0, 0, 0, 32'h2000 + i));
        in_q.push_back(mk(0, 1, 3, 32'hDEADBEEF));
        for (int i = 0; i < 14; i++) in_q.push_back(mk(i == 0, 0, 0, 32'h3000 + i));
        in_q.push_back(mk(0, 1, 0, 32'hCAFEF00D));
        send(); drain();
        chk("t3_count", 36'(out_q.size() - base), 36'd31);
        chk("t3_last16", out_q[base+15], mk(0, 1, 3, 32'hDEADBEEF));
        chk("t3_last15", out_q[base+30], mk(0, 1, 0, 32'hCAFEF00D));
        for (int i = 0; i < 31; i++) chk("t3_body", out_q[base+i], in_q[i]);
        chk("t3_pad_count", 36'(pad_count), 36'd2);
        chk("t3_latency", 36'(lat_viol), 36'd0);

        // 3-line frame with dst_rdy_i toggling
        base = out_q.size();
        toggle = 1'b1;
        in_q = '{mk(1, 0, 0, 32'h01010101), mk(0, 0, 0, 32'h02020202), mk(0, 1, 3, 32'h03030303)};
        send(); drain();
        toggle = 1'b0; dst_rdy_i = 1'b1;
        tick();
        chk("t4_count", 36'(out_q.size() - base), 36'd15);
        chk("t4_line0", out_q[base], mk(1, 0, 0, 32'h01010101));
        chk("t4_line1", out_q[base+1], mk(0, 0, 0, 32'h02020202));
        chk("t4_line2", out_q[base+2], mk(0, 0, 0, 32'h03030300));
        for (int i = 3; i < 14; i++) chk("t4_pad", out_q[base+i], 36'd0);
        chk("t4_last", out_q[base+14], mk(0, 1, 0, 32'h0));
        chk("t4_pad_count", 36'(pad_count), 36'd3);
        chk("t4_pad_dst_rdy", 36'(pad_rdy_viol), 36'd0);

        // Disable padding, 1-line frame passes unchanged
        set_stb = 1'b1; set_addr = 8'd0; set_data = 32'd0;
        tick();
        set_stb = 1'b0;
        tick();
        base = out_q.size();
        in_q = '{mk(1, 1, 2, 32'h55667788)};
        send(); drain();
        chk("t5_count", 36'(out_q.size() - base), 36'd1);
        chk("t5_line", out_q[base], mk(1, 1, 2, 32'h55667788));
        chk("t5_pad_count", 36'(pad_count), 36'd3);
        chk("t5_debug_en", 36'(debug[29]), 36'd0);

        // Re-enable, 2-line frame is padded
        set_stb = 1'b1; set_data = 32'd1;
        tick();
        set_stb = 1'b0;
        tick();
        base = out_q.size();
        in_q = '{mk(1, 0, 0, 32'h01020304), mk(0, 1, 3, 32'h05060708)};
        send(); drain();
        chk("t5b_count", 36'(out_q.size() - base), 36'd15);
        chk("t5b_line1", out_q[base+1], mk(0, 0, 0, 32'h05060700));
        chk("t5b_last", out_q[base+14], mk(0, 1, 0, 32'h0));
        chk("t5b_pad_count", 36'(pad_count), 36'd4);

        // clear on the 5th PAD cycle
        base = out_q.size();
        in_q = '{mk(1, 1, 0, 32'h99999999)};
        send();
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("t6_src_rdy_idle", 36'(src_rdy_o), 36'd0);
        chk("t6_line_cnt", 36'(debug[28:21]), 36'd0);
        chk("t6_count", 36'(out_q.size() - base), 36'd6);
        chk("t6_pad_count", 36'(pad_count), 36'd5);
        base = out_q.size();
        in_q = {};
        for (int i = 0; i < 19; i++) in_q.push_back(mk(i == 0, 0, 0, 32'h4000 + i));
        in_q.push_back(mk(0, 1, 2, 32'hABCDEF01));
        send(); drain();
        chk("t6_frame_count", 36'(out_q.size() - base), 36'd20);
        for (int i = 0; i < 20; i++) chk("t6_body", out_q[base+i], in_q[i]);
        chk("t6_pad_count_after", 36'(pad_count), 36'd5);
        chk("end_latency", 36'(lat_viol), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
